rv32v_mem_lane_sequencer: RTL and testbench
===========================================

# rv32v_mem_lane_sequencer

Walks the lanes of one vector memory micro-op and issues one scalar access per active lane to the load/store controller (LSC) port. Sits between the vector issue stage and the LSC. It latches the per-lane address, data and mask at start and skips masked lanes. It handles the ready handshake, extracts and zero-extends load data per element width, and reports completion and misalignment back to the vector pipeline.

## Interface
- NUM_LANES, default 4: lanes per micro-op; must be a power of two ≥ 2.
- LW, default $clog2(NUM_LANES): lane index width.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  begin a micro-op; accepted only in IDLE.
- is_load, is_store  in  1 each  operation type, sampled with start.
- veew  in  2  element width (vsew_t): 0=8b, 1=16b, 2=32b; 3 is treated as 32b.
- lane_mask  in  NUM_LANES  1 = active, 0 = masked.
- lane_addr  in  NUM_LANES×32  per-lane byte address.
- lane_wdata  in  NUM_LANES×32  per-lane store data, right-aligned element.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse; the micro-op is complete.
- misalign  out  1  sticky per micro-op; at least one active lane was misaligned.
- lane_rdata  out  NUM_LANES×32  zero-extended load elements.
- lane_rvalid  out  NUM_LANES  lane load completed this micro-op.
- curr_lane  out  LW  lane currently presented to the LSC.
- lsc_dren, lsc_dwen  out  1 each  LSC request strobes.
- lsc_addr  out  32  word-aligned address (addr & ~3).
- lsc_wdata  out  32  store data replicated into the byte lanes.
- lsc_byte_en  out  4  byte enables.
- lsc_ready  in  1  access completes this cycle; rdata is valid.
- lsc_rdata  in  32  raw load word.

## Operation
- States: IDLE, ISSUE, DONE. The state type is defined in the package.
- IDLE → ISSUE on start with exactly one of is_load/is_store set. The block latches op type, veew, addr, wdata and pending = lane_mask. It clears lane_rvalid, lane_rdata and misalign.
- Start with both or neither of is_load/is_store set is ignored; the block stays in IDLE.
- Start while not in IDLE is ignored.
- In ISSUE, curr_lane = lowest set bit of pending.
  - Lane aligned: drive lsc_dren or lsc_dwen, and hold addr, wdata and byte_en constant until lsc_ready.
  - Lane misaligned (16b with addr[0]=1; 32b with addr[1:0]≠0): no request is issued. Set misalign, clear the pending bit, and spend one cycle.
- Byte enables and data placement:
  - 8b: byte_en = 1<<addr[1:0], wdata byte replicated ×4.
  - 16b: byte_en = 3<<{addr[1],0}, wdata half replicated ×2.
  - 32b: byte_en = 4'hF.
- Load extraction: rdata >> (8·addr[1:0]), masked to the element width, zero-extended.
- On lsc_ready in ISSUE: clear the pending bit for curr_lane. For loads, write lane_rdata[curr_lane] and set lane_rvalid[curr_lane].
- When pending becomes 0: ISSUE → DONE. If the latched mask is all zero, IDLE → ISSUE → DONE with no LSC strobe.
- DONE: done=1 for exactly one cycle, then → IDLE.
- lane_rdata and lane_rvalid hold their values until the next accepted start.
- lsc_ready is ignored outside ISSUE and on misaligned-skip cycles.

## Timing
- Reset values (also RST mid-operation, which takes priority over all inputs):
  - state=IDLE, pending=0.
  - All outputs 0: busy, done, misalign, curr_lane, lsc_dren, lsc_dwen, lsc_addr, lsc_wdata, lsc_byte_en, lane_rdata, lane_rvalid.
  - An in-flight LSC access is abandoned.
- Start in cycle 0 → busy and the first request are visible in cycle 1. LSC outputs are combinational from registered state.
- Ready in cycle k → the next lane's request appears in cycle k+1. Minimum one cycle per lane.
- Load data is visible on lane_rdata in cycle k+1.
- Last ready in cycle k → done in cycle k+1 → IDLE in cycle k+2. A new start is accepted in cycle k+2.
- Best case for N active lanes with ready tied high: done in cycle N+1.
- No combinational path from lsc_ready to the lsc_* outputs.

## Structure
- The package rv32v_types_pkg holds NUM_LANES, vsew_t and lane_seq_state_t.
- Sub-module rv32v_lane_pick: combinational lowest-set-bit priority encoder. Input pending, outputs idx[LW] and any.
- Byte-enable generation and load extraction are local functions.

## Test plan
- Load, 32b, mask 4'b1111, addr 0x100/0x104/0x108/0x10C, ready tied 1 → four dren cycles with lsc_addr in order; done in cycle 5; lane_rvalid=4'hF; lane_rdata equals the returned words.
- Store, 8b, mask 4'b0101, addr 0x203/0x201, wdata 0xAB/0xCD → two dwen requests only:
  - lane0: byte_en 4'b1000, wdata 0xABABABAB.
  - lane2: byte_en 4'b0010, wdata 0xCDCDCDCD.
- Ready stalled: lane0 ready delayed 3 cycles → addr, wdata and byte_en held stable; curr_lane=0 throughout; the next lane follows one cycle after ready.
- Mask 4'b0000 → no LSC strobe; done in cycle 2; busy for 2 cycles.
- 16b load, lane1 addr 0x301 (misaligned), others aligned → misalign=1; lane1 never requested; lane_rvalid=4'b1101. 16b load with rdata 0xBEEF1234 at addr 0x302 → lane_rdata 0x0000BEEF.
- RST asserted mid-ISSUE with 2 lanes pending → next cycle all outputs 0 and busy=0. A start with both is_load and is_store set is ignored.

Source files
------------

// File: rtl/rv32v_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32v_types_pkg
// Description : Shared types for the vector memory lane sequencer: default
//               lane count, element-width encoding and sequencer states.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32v_types_pkg;

    localparam int unsigned NUM_LANES = 4;

    // Element width as carried by the vector issue stage; 3 behaves as 32b
    typedef enum logic [1:0] {
        SEW_8   = 2'd0,
        SEW_16  = 2'd1,
        SEW_32  = 2'd2,
        SEW_32X = 2'd3
    } vsew_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } lane_seq_state_t;

endpackage : rv32v_types_pkg
`default_nettype wire

// File: rtl/rv32v_lane_pick.sv
`default_nettype none
// ============================================================================
// Module      : rv32v_lane_pick
// Description : Lowest-set-bit priority encoder over the pending lane vector.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32v_lane_pick #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned LW        = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] pending,
    output logic [LW-1:0]        idx,
    output logic                 any
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx = LW'(i);
            end
        end
        any = |pending;
    end

endmodule : rv32v_lane_pick
`default_nettype wire

// File: rtl/rv32v_mem_lane_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rv32v_mem_lane_sequencer
// Description : Walks the active lanes of one vector memory micro-op and
//               issues one scalar access per lane to the LSC port. Masked
//               lanes are skipped, misaligned lanes are dropped and flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32v_mem_lane_sequencer #(
    parameter int unsigned NUM_LANES = rv32v_types_pkg::NUM_LANES,
    parameter int unsigned LW        = $clog2(NUM_LANES)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        start,
    input  logic                        is_load,
    input  logic                        is_store,
    input  logic [1:0]                  veew,
    input  logic [NUM_LANES-1:0]        lane_mask,
    input  logic [NUM_LANES-1:0][31:0]  lane_addr,
    input  logic [NUM_LANES-1:0][31:0]  lane_wdata,
    output logic                        busy,
    output logic                        done,
    output logic                        misalign,
    output logic [NUM_LANES-1:0][31:0]  lane_rdata,
    output logic [NUM_LANES-1:0]        lane_rvalid,
    output logic [LW-1:0]               curr_lane,
    output logic                        lsc_dren,
    output logic                        lsc_dwen,
    output logic [31:0]                 lsc_addr,
    output logic [31:0]                 lsc_wdata,
    output logic [3:0]                  lsc_byte_en,
    input  logic                        lsc_ready,
    input  logic [31:0]                 lsc_rdata
);

    import rv32v_types_pkg::*;

    // ------------------------------------------------------------------------
    // Element-width helpers
    // ------------------------------------------------------------------------
    function automatic logic f_misaligned(input vsew_t sew, input logic [1:0] a);
        case (sew)
            SEW_8:   f_misaligned = 1'b0;
            SEW_16:  f_misaligned = a[0];
            default: f_misaligned = (a != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] f_byte_en(input vsew_t sew, input logic [1:0] a);
        case (sew)
            SEW_8:   f_byte_en = 4'b0001 << a;
            SEW_16:  f_byte_en = 4'b0011 << {a[1], 1'b0};
            default: f_byte_en = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] f_wdata_place(input vsew_t sew, input logic [31:0] d);
        case (sew)
            SEW_8:   f_wdata_place = {4{d[7:0]}};
            SEW_16:  f_wdata_place = {2{d[15:0]}};
            default: f_wdata_place = d;
        endcase
    endfunction

    function automatic logic [31:0] f_load_extract(input vsew_t sew, input logic [1:0] a,
                                                   input logic [31:0] rd);
        logic [31:0] v_sh;
        v_sh = rd >> {a, 3'b000};
        case (sew)
            SEW_8:   f_load_extract = {24'h0, v_sh[7:0]};
            SEW_16:  f_load_extract = {16'h0, v_sh[15:0]};
            default: f_load_extract = v_sh;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    lane_seq_state_t                r_state;
    lane_seq_state_t                w_state_nxt;
    logic                           r_is_load;
    vsew_t                          r_sew;
    logic [NUM_LANES-1:0][31:0]     r_addr;
    logic [NUM_LANES-1:0][31:0]     r_wdata;
    logic [NUM_LANES-1:0][31:0]     r_rdata;
    logic [NUM_LANES-1:0]           r_pending;
    logic [NUM_LANES-1:0]           r_rvalid;
    logic                           r_misalign;

    logic [LW-1:0]                  w_idx;
    logic                           w_any;
    logic                           w_in_issue;
    logic                           w_start_ok;
    logic [31:0]                    w_addr;
    logic                           w_mis;
    logic                           w_req;
    logic                           w_skip;
    logic                           w_accept;
    logic                           w_clear;
    logic [NUM_LANES-1:0]           w_pending_nxt;

    rv32v_lane_pick #(
        .NUM_LANES (NUM_LANES),
        .LW        (LW)
    ) u_lane_pick (
        .pending (r_pending),
        .idx     (w_idx),
        .any     (w_any)
    );

    // Current-lane decode: request vs misaligned skip, and the pending update
    always_comb begin
        w_in_issue    = (r_state == ST_ISSUE);
        w_start_ok    = start && (is_load ^ is_store) && (r_state == ST_IDLE);
        w_addr        = r_addr[w_idx];
        w_mis         = f_misaligned(r_sew, w_addr[1:0]);
        w_req         = w_in_issue && w_any && !w_mis;
        w_skip        = w_in_issue && w_any && w_mis;
        w_accept      = w_req && lsc_ready;
        w_clear       = w_skip || w_accept;
        w_pending_nxt = r_pending;
        if (w_clear) begin
            w_pending_nxt = r_pending & ~(NUM_LANES'(1) << w_idx);
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an all-zero mask still spends one ISSUE cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok) w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (w_pending_nxt == '0) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: LSC strobes derive only from registered state, never lsc_ready
    always_comb begin
        busy        = (r_state != ST_IDLE);
        done        = (r_state == ST_DONE);
        misalign    = r_misalign;
        lane_rdata  = r_rdata;
        lane_rvalid = r_rvalid;
        curr_lane   = w_in_issue ? w_idx : '0;
        lsc_dren    = w_req && r_is_load;
        lsc_dwen    = w_req && !r_is_load;
        lsc_addr    = w_req ? {w_addr[31:2], 2'b00} : 32'h0;
        lsc_wdata   = w_req ? f_wdata_place(r_sew, r_wdata[w_idx]) : 32'h0;
        lsc_byte_en = w_req ? f_byte_en(r_sew, w_addr[1:0]) : 4'h0;
    end

    // Operand latch at start, lane retirement and load write-back
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_is_load  <= 1'b0;
            r_sew      <= SEW_8;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_pending  <= '0;
            r_rdata    <= '0;
            r_rvalid   <= '0;
            r_misalign <= 1'b0;
        end else if (w_start_ok) begin
            r_is_load  <= is_load;
            r_sew      <= vsew_t'(veew);
            r_addr     <= lane_addr;
            r_wdata    <= lane_wdata;
            r_pending  <= lane_mask;
            r_rdata    <= '0;
            r_rvalid   <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_skip) begin
                r_misalign <= 1'b1;
            end
            if (w_accept && r_is_load) begin
                r_rdata[w_idx]  <= f_load_extract(r_sew, w_addr[1:0], lsc_rdata);
                r_rvalid[w_idx] <= 1'b1;
            end
        end
    end

endmodule : rv32v_mem_lane_sequencer
`default_nettype wire

// File: tb/tb_rv32v_mem_lane_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32v_mem_lane_sequencer
// Description : Directed self-checking bench for rv32v_mem_lane_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32v_mem_lane_sequencer;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              start = 1'b0;
    logic              is_load = 1'b0;
    logic              is_store = 1'b0;
    logic [1:0]        veew = 2'd0;
    logic [3:0]        lane_mask = 4'h0;
    logic [3:0][31:0]  lane_addr = '0;
    logic [3:0][31:0]  lane_wdata = '0;
    logic              busy;
    logic              done;
    logic              misalign;
    logic [3:0][31:0]  lane_rdata;
    logic [3:0]        lane_rvalid;
    logic [1:0]        curr_lane;
    logic              lsc_dren;
    logic              lsc_dwen;
    logic [31:0]       lsc_addr;
    logic [31:0]       lsc_wdata;
    logic [3:0]        lsc_byte_en;
    logic              lsc_ready = 1'b0;
    logic [31:0]       lsc_rdata = 32'h0;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] words [4];

    rv32v_mem_lane_sequencer dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .is_load     (is_load),
        .is_store    (is_store),
        .veew        (veew),
        .lane_mask   (lane_mask),
        .lane_addr   (lane_addr),
        .lane_wdata  (lane_wdata),
        .busy        (busy),
        .done        (done),
        .misalign    (misalign),
        .lane_rdata  (lane_rdata),
        .lane_rvalid (lane_rvalid),
        .curr_lane   (curr_lane),
        .lsc_dren    (lsc_dren),
        .lsc_dwen    (lsc_dwen),
        .lsc_addr    (lsc_addr),
        .lsc_wdata   (lsc_wdata),
        .lsc_byte_en (lsc_byte_en),
        .lsc_ready   (lsc_ready),
        .lsc_rdata   (lsc_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one start cycle; on return the bench sits in cycle 1
    task automatic start_op(input logic ld, input logic st, input logic [1:0] sew,
                            input logic [3:0] mask);
        start     = 1'b1;
        is_load   = ld;
        is_store  = st;
        veew      = sew;
        lane_mask = mask;
        tick();
        start     = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_busy",    32'(busy), 32'h0);
        chk("rst_byte_en", 32'(lsc_byte_en), 32'h0);
        RST = 1'b0;
        tick();

        // ---------------- 32b load, all lanes, ready tied high ----------------
        words[0] = 32'hDEADBEEF;
        words[1] = 32'h01234567;
        words[2] = 32'h89ABCDEF;
        words[3] = 32'hCAFEF00D;
        lane_addr = {32'h10C, 32'h108, 32'h104, 32'h100};
        lsc_ready = 1'b1;
        start_op(1'b1, 1'b0, 2'd2, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            chk("ld32_busy", 32'(busy), 32'h1);
            chk("ld32_dren", 32'(lsc_dren), 32'h1);
            chk("ld32_addr", lsc_addr, 32'h100 + 32'(4 * i));
            chk("ld32_lane", 32'(curr_lane), 32'(i));
            chk("ld32_ben",  32'(lsc_byte_en), 32'hF);
            lsc_rdata = words[i];
            tick();
        end
        chk("ld32_done",   32'(done), 32'h1);
        chk("ld32_strobe", 32'(lsc_dren), 32'h0);
        tick();
        chk("ld32_idle",   32'(busy), 32'h0);
        chk("ld32_rvalid", 32'(lane_rvalid), 32'hF);
        for (int i = 0; i < 4; i++) begin
            chk("ld32_rdata", lane_rdata[i], words[i]);
        end

        // ---------------- 8b store, mask 0101 ----------------
        lane_addr  = {32'h0, 32'h201, 32'h0, 32'h203};
        lane_wdata = {32'h0, 32'h000000CD, 32'h0, 32'h000000AB};
        start_op(1'b0, 1'b1, 2'd0, 4'b0101);
        chk("st8_l0_dwen", 32'(lsc_dwen), 32'h1);
        chk("st8_l0_dren", 32'(lsc_dren), 32'h0);
        chk("st8_l0_addr", lsc_addr, 32'h200);
        chk("st8_l0_ben",  32'(lsc_byte_en), 32'h8);
        chk("st8_l0_wd",   lsc_wdata, 32'hABABABAB);
        tick();
        chk("st8_l2_lane", 32'(curr_lane), 32'h2);
        chk("st8_l2_dwen", 32'(lsc_dwen), 32'h1);
        chk("st8_l2_ben",  32'(lsc_byte_en), 32'h2);
        chk("st8_l2_wd",   lsc_wdata, 32'hCDCDCDCD);
        tick();
        chk("st8_done",    32'(done), 32'h1);
        chk("st8_dwen_off", 32'(lsc_dwen), 32'h0);
        chk("st8_rvalid",  32'(lane_rvalid), 32'h0);
        tick();

        // ---------------- 32b store with ready stalled on lane0 ----------------
        lane_addr  = {32'h0, 32'h0, 32'h404, 32'h400};
        lane_wdata = {32'h0, 32'h0, 32'h9ABCDEF0, 32'h12345678};
        lsc_ready  = 1'b0;
        start_op(1'b0, 1'b1, 2'd2, 4'b0011);
        for (int i = 0; i < 3; i++) begin
            chk("stall_lane", 32'(curr_lane), 32'h0);
            chk("stall_dwen", 32'(lsc_dwen), 32'h1);
            chk("stall_addr", lsc_addr, 32'h400);
            chk("stall_wd",   lsc_wdata, 32'h12345678);
            chk("stall_ben",  32'(lsc_byte_en), 32'hF);
            tick();
        end
        lsc_ready = 1'b1;
        tick();
        chk("stall_next_lane", 32'(curr_lane), 32'h1);
        chk("stall_next_addr", lsc_addr, 32'h404);
        chk("stall_next_wd",   lsc_wdata, 32'h9ABCDEF0);
        tick();
        chk("stall_done", 32'(done), 32'h1);
        tick();

        // ---------------- empty mask ----------------
        start_op(1'b1, 1'b0, 2'd2, 4'b0000);
        chk("empty_busy1", 32'(busy), 32'h1);
        chk("empty_dren",  32'(lsc_dren), 32'h0);
        chk("empty_done1", 32'(done), 32'h0);
        tick();
        chk("empty_done2", 32'(done), 32'h1);
        chk("empty_busy2", 32'(busy), 32'h1);
        tick();
        chk("empty_busy3", 32'(busy), 32'h0);
        chk("empty_done3", 32'(done), 32'h0);

        // ---------------- 16b load with a misaligned lane ----------------
        lane_addr = {32'h304, 32'h302, 32'h301, 32'h300};
        lsc_rdata = 32'hBEEF1234;
        start_op(1'b1, 1'b0, 2'd1, 4'b1111);
        chk("h16_l0_addr", lsc_addr, 32'h300);
        chk("h16_l0_ben",  32'(lsc_byte_en), 32'h3);
        tick();
        chk("h16_skip_lane", 32'(curr_lane), 32'h1);
        chk("h16_skip_dren", 32'(lsc_dren), 32'h0);
        tick();
        chk("h16_l2_lane", 32'(curr_lane), 32'h2);
        chk("h16_l2_ben",  32'(lsc_byte_en), 32'hC);
        chk("h16_l2_addr", lsc_addr, 32'h300);
        chk("h16_mis",     32'(misalign), 32'h1);
        tick();
        chk("h16_l3_addr", lsc_addr, 32'h304);
        tick();
        chk("h16_done",    32'(done), 32'h1);
        chk("h16_rvalid",  32'(lane_rvalid), 32'hD);
        chk("h16_rdata0",  lane_rdata[0], 32'h00001234);
        chk("h16_rdata1",  lane_rdata[1], 32'h00000000);
        chk("h16_rdata2",  lane_rdata[2], 32'h0000BEEF);
        chk("h16_rdata3",  lane_rdata[3], 32'h00001234);
        tick();
        chk("h16_mis_hold", 32'(misalign), 32'h1);

        // ---------------- reset mid-ISSUE, then illegal starts ----------------
        lane_addr = {32'h50C, 32'h508, 32'h504, 32'h500};
        lsc_rdata = 32'h77777777;
        start_op(1'b1, 1'b0, 2'd2, 4'b1111);
        chk("mid_mis_clr", 32'(misalign), 32'h0);
        tick();
        tick();
        chk("mid_lane", 32'(curr_lane), 32'h2);
        RST       = 1'b1;
        lsc_ready = 1'b0;
        tick();
        RST = 1'b0;
        chk("rst_mid_busy",   32'(busy), 32'h0);
        chk("rst_mid_dren",   32'(lsc_dren), 32'h0);
        chk("rst_mid_lane",   32'(curr_lane), 32'h0);
        chk("rst_mid_addr",   lsc_addr, 32'h0);
        chk("rst_mid_rvalid", 32'(lane_rvalid), 32'h0);
        chk("rst_mid_rdata0", lane_rdata[0], 32'h0);
        chk("rst_mid_done",   32'(done), 32'h0);
        tick();
        chk("rst_mid_stay",   32'(busy), 32'h0);
        start_op(1'b1, 1'b1, 2'd2, 4'b1111);
        chk("both_busy", 32'(busy), 32'h0);
        chk("both_dren", 32'(lsc_dren), 32'h0);
        chk("both_dwen", 32'(lsc_dwen), 32'h0);
        start_op(1'b0, 1'b0, 2'd2, 4'b1111);
        chk("neither_busy", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_rv32v_mem_lane_sequencer
`default_nettype wire
